// File: rtl/thumb_decode_queue.sv
// Thumb-16 decode stage feeding a DEPTH-entry micro-op queue with flush and PC tracking.
// Latency 1 cycle into an empty queue; in_ready drops when full, with no pass-through.
module thumb_decode_queue #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4,
  parameter int UOP_W     = 5,
  parameter int DEPTH     = 2,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_instr,
  input  logic [DATA_W-1:0]    in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [UOP_W-1:0]     uop,
  output logic                 num_to_rhs,
  output logic [DATA_W-1:0]    num,
  output logic [REG_SEL_W-1:0] sel_p0,
  output logic [REG_SEL_W-1:0] sel_p1,
  output logic [REG_SEL_W-1:0] sel_in,
  output logic [3:0]           cond,
  output logic [DATA_W-1:0]    out_pc,
  output logic                 explose,
  output logic [ERR_W-1:0]     err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [UOP_W-1:0]     uop;
    logic                 num_to_rhs;
    logic [DATA_W-1:0]    num;
    logic [REG_SEL_W-1:0] sel_p0;
    logic [REG_SEL_W-1:0] sel_p1;
    logic [REG_SEL_W-1:0] sel_in;
    logic [3:0]           cond;
    logic [DATA_W-1:0]    pc;
    logic                 explose;
  } entry_t;

  function automatic logic [REG_SEL_W-1:0] rsel(input logic [2:0] r);
    return REG_SEL_W'(r);
  endfunction

  function automatic entry_t decode(input logic [15:0] i, input logic [DATA_W-1:0] pc);
    entry_t e;
    e      = '0;
    e.cond = 4'b1110;
    e.pc   = pc;
    if (i[15:11] == 5'b00000) begin
      if (i[10:6] != 5'd0) begin
        e.uop = UOP_W'(6); e.num = DATA_W'(i[10:6]);
        e.sel_p1 = rsel(i[5:3]); e.sel_in = rsel(i[2:0]); e.num_to_rhs = 1'b1;
      end else begin
        e.uop = UOP_W'(8); e.sel_p0 = rsel(i[5:3]); e.sel_in = rsel(i[2:0]);
      end
    end else if (i[15:11] == 5'b00011) begin
      e.uop    = i[9] ? UOP_W'(2) : UOP_W'(1);
      e.sel_p1 = rsel(i[5:3]);
      e.sel_in = rsel(i[2:0]);
      if (i[10]) begin
        e.num = DATA_W'(i[8:6]); e.num_to_rhs = 1'b1;
      end else begin
        e.sel_p0 = rsel(i[8:6]);
      end
    end else if (i[15:13] == 3'b001) begin
      e.num        = DATA_W'(i[7:0]);
      e.num_to_rhs = 1'b1;
      case (i[12:11])
        2'b00:   begin e.uop = UOP_W'(8); e.sel_in = rsel(i[10:8]); end
        2'b01:   begin e.uop = UOP_W'(5); e.sel_p1 = rsel(i[10:8]); end
        2'b10:   begin e.uop = UOP_W'(1); e.sel_p1 = rsel(i[10:8]); e.sel_in = rsel(i[10:8]); end
        default: begin e.uop = UOP_W'(2); e.sel_p1 = rsel(i[10:8]); e.sel_in = rsel(i[10:8]); end
      endcase
    end else if (i[15:6] == 10'b0100000001) begin
      e.uop = UOP_W'(4); e.sel_p0 = rsel(i[2:0]); e.sel_in = rsel(i[2:0]); e.sel_p1 = rsel(i[5:3]);
    end else if (i[15:12] == 4'b0110) begin
      // word-scaled offset; bit 11 splits store from load
      e.num = DATA_W'({i[10:6], 2'b00}); e.num_to_rhs = 1'b1; e.sel_p1 = rsel(i[5:3]);
      if (i[11]) begin
        e.uop = UOP_W'(10); e.sel_in = rsel(i[2:0]);
      end else begin
        e.uop = UOP_W'(9); e.sel_p0 = rsel(i[2:0]);
      end
    end else if (i[15:11] == 5'b11100) begin
      e.uop = UOP_W'(11);
      e.num = {{(DATA_W-11){i[10]}}, i[10:0]} << 1;
    end else if (i[15:12] == 4'b1101 && i[11:9] != 3'b111) begin
      e.uop  = UOP_W'(12);
      e.cond = i[11:8];
      e.num  = {{(DATA_W-8){i[7]}}, i[7:0]} << 1;
    end else begin
      e.cond    = 4'b1110;
      e.explose = 1'b1;
    end
    return e;
  endfunction

  entry_t             mem [DEPTH];
  entry_t             in_dec;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push;
  logic               pop;

  assign in_dec    = decode(in_instr, in_pc);
  assign in_ready  = (count != DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (push && in_dec.explose && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dec;
  end

  // storage is not cleared, so an empty queue must mask the stale head entry
  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign uop        = head.uop;
  assign num_to_rhs = head.num_to_rhs;
  assign num        = head.num;
  assign sel_p0     = head.sel_p0;
  assign sel_p1     = head.sel_p1;
  assign sel_in     = head.sel_in;
  assign cond       = head.cond;
  assign out_pc     = head.pc;
  assign explose    = head.explose;

endmodule

// File: tb/tb_thumb_decode_queue.sv
// Directed bench for thumb_decode_queue with a scoreboard of expected head entries.
module tb_thumb_decode_queue;

  typedef struct packed {
    logic [4:0]  uop;
    logic        ntr;
    logic [31:0] num;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  sin;
    logic [3:0]  cond;
    logic [31:0] pc;
    logic        exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0;
  logic [31:0] in_pc = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  uop;
  logic        num_to_rhs;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, cond;
  logic [31:0] out_pc;
  logic        explose;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, num_to_rhs2, explose2;
  logic [4:0]  uop2;
  logic [31:0] num2, out_pc2;
  logic [3:0]  sel_p02, sel_p12, sel_in2, cond2;
  logic [1:0]  err_count2;

  int   vectors = 0;
  int   miscompares = 0;
  int   udf = 0;
  bit   mon_en = 1'b0;
  exp_t cur;
  exp_t sb[$];
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  thumb_decode_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .uop(uop),
    .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1),
    .sel_in(sel_in), .cond(cond), .out_pc(out_pc), .explose(explose),
    .err_count(err_count)
  );

  thumb_decode_queue #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .uop(uop2),
    .num_to_rhs(num_to_rhs2), .num(num2), .sel_p0(sel_p02), .sel_p1(sel_p12),
    .sel_in(sel_in2), .cond(cond2), .out_pc(out_pc2), .explose(explose2),
    .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] u, input logic n, input logic [31:0] v,
                              input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                              input logic [3:0] c, input logic x);
    exp_t e;
    e = '{uop: u, ntr: n, num: v, p0: a, p1: b, sin: d, cond: c, pc: 32'h0, exp: x};
    return e;
  endfunction

  // scoreboard monitor, sampled mid-cycle while inputs are stable
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t o;
      o = {uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, cond, out_pc, explose};
      chk("out_valid", {127'b0, out_valid}, {127'b0, sb.size() != 0});
      chk("in_ready", {127'b0, in_ready}, {127'b0, sb.size() < 2});
      chk("err_count", {120'b0, err_count}, (udf > 255) ? 128'd255 : 128'(udf));
      chk("err_count_w2", {126'b0, err_count2}, (udf > 3) ? 128'd3 : 128'(udf));
      if (sb.size() != 0) chk("head", {41'b0, o}, {41'b0, sb[0]});
      else                chk("empty_head", {41'b0, o}, 128'b0);
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (in_valid && in_ready) begin
          sb.push_back(cur);
          if (cur.exp) udf++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] instr, input exp_t e);
    bit acc;
    int n;
    e.pc     = pc_ctr;
    pc_ctr   = pc_ctr + 32'd2;
    cur      = e;
    in_instr = instr;
    in_pc    = e.pc;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) chk("accept_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t e_add3;
    e_add3 = mk(5'd1, 1'b1, 32'd2, 4'd0, 4'd1, 4'd2, 4'hE, 1'b0);

    #12;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_err", {120'b0, err_count}, 128'd0);
    tick();
    mon_en = 1'b1;

    // first-transaction latency
    out_ready = 1'b1;
    push(16'h1C8A, e_add3);
    @(negedge clk);
    chk("lat_out_valid", {127'b0, out_valid}, 128'd1);
    chk("lat_uop", {123'b0, uop}, 128'd1);
    tick();
    repeat (2) tick();

    // backpressure: two fill the queue, third is held until a pop
    out_ready = 1'b0;
    push(16'h0000, mk(5'd8, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hE, 1'b0));
    push(16'h0048, mk(5'd6, 1'b1, 32'd1, 4'd0, 4'd1, 4'd0, 4'hE, 1'b0));
    cur = mk(5'd8, 1'b1, 32'd5, 4'd0, 4'd0, 4'd1, 4'hE, 1'b0);
    cur.pc = pc_ctr; pc_ctr = pc_ctr + 32'd2;
    in_instr = 16'h2105; in_pc = cur.pc; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("full_in_ready", {127'b0, in_ready}, 128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("third_accept", {127'b0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // branches and remaining formats
    push(16'hE7FE, mk(5'd11, 1'b0, 32'hFFFF_FFFC, 4'd0, 4'd0, 4'd0, 4'hE, 1'b0));
    push(16'hD1FC, mk(5'd12, 1'b0, 32'hFFFF_FFF8, 4'd0, 4'd0, 4'd0, 4'h1, 1'b0));
    push(16'h4048, mk(5'd4, 1'b0, 32'd0, 4'd0, 4'd1, 4'd0, 4'hE, 1'b0));
    push(16'h6848, mk(5'd10, 1'b1, 32'd4, 4'd0, 4'd1, 4'd0, 4'hE, 1'b0));
    push(16'h2A7F, mk(5'd5, 1'b1, 32'h7F, 4'd0, 4'd2, 4'd0, 4'hE, 1'b0));
    push(16'h3B10, mk(5'd2, 1'b1, 32'h10, 4'd0, 4'd3, 4'd3, 4'hE, 1'b0));
    repeat (3) tick();

    // undefined instructions and counter saturation
    repeat (3) push(16'hDE00, mk(5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hE, 1'b1));
    repeat (3) tick();
    @(negedge clk);
    chk("udf3_err", {120'b0, err_count}, 128'd3);
    tick();
    repeat (2) push(16'hDE00, mk(5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hE, 1'b1));
    repeat (3) tick();
    @(negedge clk);
    chk("udf5_err", {120'b0, err_count}, 128'd5);
    chk("udf5_err_w2", {126'b0, err_count2}, 128'd3);
    tick();

    // flush a full queue while fetch presents an instruction
    out_ready = 1'b0;
    push(16'h1C8A, e_add3);
    push(16'h0048, mk(5'd6, 1'b1, 32'd1, 4'd0, 4'd1, 4'd0, 4'hE, 1'b0));
    cur = mk(5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hE, 1'b1);
    in_instr = 16'hDE00; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", {127'b0, out_valid}, 128'd0);
    tick();
    // flush with room: the same-cycle push must be dropped and not counted
    push(16'h1C8A, e_add3);
    cur = mk(5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hE, 1'b1);
    in_instr = 16'hDE00; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_err_kept", {120'b0, err_count}, 128'd5);
    tick();
    out_ready = 1'b1;
    push(16'h2105, mk(5'd8, 1'b1, 32'd5, 4'd0, 4'd0, 4'd1, 4'hE, 1'b0));
    repeat (3) tick();

    // asynchronous reset with entries queued
    out_ready = 1'b0;
    push(16'h1C8A, e_add3);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("arst_uop", {123'b0, uop}, 128'd0);
    chk("arst_num", {96'b0, num}, 128'd0);
    chk("arst_pc", {96'b0, out_pc}, 128'd0);
    chk("arst_err", {120'b0, err_count}, 128'd0);
    tick();
    rst = 1'b0;
    sb.delete();
    udf = 0;
    tick();
    mon_en = 1'b1;
    out_ready = 1'b1;
    push(16'h0048, mk(5'd6, 1'b1, 32'd1, 4'd0, 4'd1, 4'd0, 4'hE, 1'b0));
    repeat (3) tick();
    mon_en = 1'b0;
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
